// File: rtl/dm_abstract_ctl_pkg.sv
// Shared types, cmderr codes, cmdtype constants and command field slices for the
// debug-module abstract command controller.
`ifndef DM_PKG_SV
`define DM_PKG_SV

`define DM_CMD_TYPE(c)    c[31:24]
`define DM_CMD_POSTINC(c) c[19]
`define DM_CMD_REGNO(c)   c[15:0]

package dm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_EXEC
  } state_e;

  localparam logic [2:0] CMDERR_NONE       = 3'd0;
  localparam logic [2:0] CMDERR_BUSY       = 3'd1;
  localparam logic [2:0] CMDERR_NOTSUP     = 3'd2;
  localparam logic [2:0] CMDERR_EXCEPTION  = 3'd3;
  localparam logic [2:0] CMDERR_HALTRESUME = 3'd4;
  localparam logic [2:0] CMDERR_BUS        = 3'd5;
  localparam logic [2:0] CMDERR_OTHER      = 3'd7;

  localparam logic [7:0] CMDTYPE_ACCESS_REGISTER = 8'd0;
  localparam logic [7:0] CMDTYPE_QUICK_ACCESS    = 8'd1;
  localparam logic [7:0] CMDTYPE_ACCESS_MEMORY   = 8'd2;

endpackage

`endif

// File: rtl/dm_abstract_ctl_cmd_check.sv
// Combinational CHECK-state verdict: whether the latched command may run given the
// core's halt state, or which cmderr code it earns.
module dm_cmd_check
  import dm_pkg::*;
(
  input  logic [7:0] cmdtype,
  input  logic       core_halted,
  output logic       pass,
  output logic [2:0] err
);

  always_comb begin
    pass = 1'b0;
    err  = CMDERR_NONE;
    unique case (cmdtype)
      CMDTYPE_ACCESS_REGISTER,
      CMDTYPE_ACCESS_MEMORY: begin
        if (core_halted) pass = 1'b1;
        else             err  = CMDERR_HALTRESUME;
      end
      // Quick access halts the core itself, so it needs a running core.
      CMDTYPE_QUICK_ACCESS: begin
        if (!core_halted) pass = 1'b1;
        else              err  = CMDERR_HALTRESUME;
      end
      default: err = CMDERR_NOTSUP;
    endcase
  end

endmodule

// File: rtl/dm_abstract_ctl.sv
// Abstract command controller: IDLE -> CHECK -> EXEC sequencing, sticky cmderr and
// regno post-increment. Define DM_AUTOEXEC_EN to let autoexec_trig re-run the command.
module dm_abstract_ctl
  import dm_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dmactive,
  input  logic        cmd_wr,
  input  logic [31:0] cmd_wdata,
  input  logic        cmderr_clr,
  input  logic [2:0]  cmderr_wdata,
  input  logic        autoexec_trig,
  input  logic        core_halted,
  input  logic        core_done,
  input  logic        core_exception,
  input  logic        core_bus,
  input  logic        core_haltresume,
  output logic        exec,
  output logic [31:0] command,
  output logic        busy,
  output logic [2:0]  cmderr
);

  state_e      state_q, state_d;
  logic [31:0] cmd_q, cmd_d;
  logic [2:0]  cmderr_q, cmderr_d;
  logic        exec_q, busy_q;
  logic        err_set;
  logic [2:0]  err_code;
  logic        chk_pass;
  logic [2:0]  chk_err;
  logic        auto_req;

`ifdef DM_AUTOEXEC_EN
  assign auto_req = autoexec_trig;
`else
  logic unused_autoexec;
  assign unused_autoexec = autoexec_trig;
  assign auto_req        = 1'b0;
`endif

  dm_cmd_check u_cmd_check (
    .cmdtype     (`DM_CMD_TYPE(cmd_q)),
    .core_halted (core_halted),
    .pass        (chk_pass),
    .err         (chk_err)
  );

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    err_set  = 1'b0;
    err_code = CMDERR_NONE;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_wr) begin
          if (cmderr_q == CMDERR_NONE) begin
            cmd_d   = cmd_wdata;
            state_d = ST_CHECK;
          end
        end else if (auto_req && cmderr_q == CMDERR_NONE) begin
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (chk_pass) begin
          state_d = ST_EXEC;
        end else begin
          state_d  = ST_IDLE;
          err_set  = 1'b1;
          err_code = chk_err;
        end
      end
      ST_EXEC: begin
        if (core_done) begin
          state_d = ST_IDLE;
          if (core_exception) begin
            err_set  = 1'b1;
            err_code = CMDERR_EXCEPTION;
          end else if (core_bus) begin
            err_set  = 1'b1;
            err_code = CMDERR_BUS;
          end else if (core_haltresume) begin
            err_set  = 1'b1;
            err_code = CMDERR_HALTRESUME;
          end else if (`DM_CMD_TYPE(cmd_q) == CMDTYPE_ACCESS_REGISTER &&
                       `DM_CMD_POSTINC(cmd_q)) begin
            `DM_CMD_REGNO(cmd_d) = `DM_CMD_REGNO(cmd_q) + 16'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A busy violation only reports when nothing else in this cycle already did.
    if (state_q != ST_IDLE && (cmd_wr || auto_req) && !err_set) begin
      err_set  = 1'b1;
      err_code = CMDERR_BUSY;
    end

    if (err_set)
      cmderr_d = (cmderr_q == CMDERR_NONE) ? err_code : cmderr_q;
    else if (cmderr_clr)
      cmderr_d = cmderr_q & ~cmderr_wdata;
    else
      cmderr_d = cmderr_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !dmactive) begin
      state_q  <= ST_IDLE;
      cmd_q    <= '0;
      cmderr_q <= '0;
      exec_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      cmderr_q <= cmderr_d;
      exec_q   <= (state_d == ST_EXEC);
      busy_q   <= (state_d != ST_IDLE);
    end
  end

  assign exec    = exec_q;
  assign busy    = busy_q;
  assign command = cmd_q;
  assign cmderr  = cmderr_q;

endmodule

// File: tb/tb_dm_abstract_ctl.sv
// Directed bench for dm_abstract_ctl; autoexec checks follow DM_AUTOEXEC_EN.
module tb_dm_abstract_ctl;

  logic        clk = 1'b0;
  logic        rst_n, dmactive, cmd_wr, cmderr_clr, autoexec_trig;
  logic [31:0] cmd_wdata;
  logic [2:0]  cmderr_wdata;
  logic        core_halted, core_done, core_exception, core_bus, core_haltresume;
  logic        exec, busy;
  logic [31:0] command;
  logic [2:0]  cmderr;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;

  dm_abstract_ctl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .dmactive        (dmactive),
    .cmd_wr          (cmd_wr),
    .cmd_wdata       (cmd_wdata),
    .cmderr_clr      (cmderr_clr),
    .cmderr_wdata    (cmderr_wdata),
    .autoexec_trig   (autoexec_trig),
    .core_halted     (core_halted),
    .core_done       (core_done),
    .core_exception  (core_exception),
    .core_bus        (core_bus),
    .core_haltresume (core_haltresume),
    .exec            (exec),
    .command         (command),
    .busy            (busy),
    .cmderr          (cmderr)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cmd_wr          = 1'b0;
    cmderr_clr      = 1'b0;
    autoexec_trig   = 1'b0;
    core_done       = 1'b0;
    core_exception  = 1'b0;
    core_bus        = 1'b0;
    core_haltresume = 1'b0;
  endtask

  task automatic write_cmd(input logic [31:0] c);
    cmd_wr    = 1'b1;
    cmd_wdata = c;
    tick();
  endtask

  task automatic clear_err(input logic [2:0] mask);
    cmderr_clr   = 1'b1;
    cmderr_wdata = mask;
    tick();
  endtask

  task automatic finish_clean();
    core_done = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; dmactive = 1'b1; cmd_wr = 1'b0; cmd_wdata = '0;
    cmderr_clr = 1'b0; cmderr_wdata = '0; autoexec_trig = 1'b0;
    core_halted = 1'b1; core_done = 1'b0; core_exception = 1'b0;
    core_bus = 1'b0; core_haltresume = 1'b0;
    tick(); tick();
    check_eq("rst_exec", exec, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_cmderr", cmderr, 0);
    check_eq("rst_command", command, 0);
    rst_n = 1'b1;
    tick();

    // Clean access-register with post-increment
    write_cmd(32'h0008_1000);
    check_eq("t1_busy_check", busy, 1);
    check_eq("t1_exec_check", exec, 0);
    check_eq("t1_command", command, 32'h0008_1000);
    tick();
    check_eq("t1_exec_first", exec, 1);
    tick();
    check_eq("t1_exec_held", exec, 1);
    finish_clean();
    check_eq("t1_exec_done", exec, 0);
    check_eq("t1_busy_done", busy, 0);
    check_eq("t1_cmderr", cmderr, 0);
    check_eq("t1_regno_inc", command, 32'h0008_1001);

    // Register access with core running
    core_halted = 1'b0;
    write_cmd(32'h0000_1000);
    check_eq("t2_busy", busy, 1);
    tick();
    check_eq("t2_cmderr", cmderr, 4);
    check_eq("t2_exec", exec, 0);
    check_eq("t2_busy_idle", busy, 0);
    core_halted = 1'b1;
    write_cmd(32'h0000_2000);
    check_eq("t2_ignored_busy", busy, 0);
    check_eq("t2_ignored_cmd", command, 32'h0000_1000);
    check_eq("t2_ignored_err", cmderr, 4);
    clear_err(3'd7);
    check_eq("t2_cleared", cmderr, 0);
    write_cmd(32'h0000_2000);
    check_eq("t2_accept_busy", busy, 1);
    tick();
    check_eq("t2_accept_exec", exec, 1);
    finish_clean();
    check_eq("t2_no_postinc", command, 32'h0000_2000);
    check_eq("t2_err_after", cmderr, 0);

    // Quick access while halted, and partial W1C masks
    write_cmd(32'h0100_0000);
    tick();
    check_eq("t3_quick_halted", cmderr, 4);
    check_eq("t3_exec", exec, 0);
    clear_err(3'd3);
    check_eq("t3_partial_clr", cmderr, 4);
    clear_err(3'd4);
    check_eq("t3_bit_clr", cmderr, 0);

    // Unsupported cmdtype
    write_cmd(32'h0500_0000);
    tick();
    check_eq("t4_notsup", cmderr, 2);
    check_eq("t4_exec", exec, 0);
    clear_err(3'd7);

    // Write while executing, then exception must not overwrite busy error
    write_cmd(32'h0200_0010);
    tick();
    check_eq("t5_exec", exec, 1);
    write_cmd(32'h0000_3333);
    check_eq("t5_busy_err", cmderr, 1);
    check_eq("t5_cmd_kept", command, 32'h0200_0010);
    check_eq("t5_exec_kept", exec, 1);
    core_done = 1'b1; core_exception = 1'b1;
    tick();
    check_eq("t5_err_sticky", cmderr, 1);
    check_eq("t5_exec_off", exec, 0);
    clear_err(3'd7);

    // Completion error priority
    write_cmd(32'h0000_0005);
    tick();
    core_done = 1'b1; core_exception = 1'b1; core_bus = 1'b1;
    tick();
    check_eq("t6_exc_over_bus", cmderr, 3);
    clear_err(3'd7);
    write_cmd(32'h0000_0005);
    tick();
    core_done = 1'b1; core_bus = 1'b1; core_haltresume = 1'b1;
    tick();
    check_eq("t6_bus_over_hr", cmderr, 5);
    clear_err(3'd7);

    // Set beats clear in same cycle; regno wraps
    write_cmd(32'h0008_FFFF);
    tick();
    cmderr_clr = 1'b1; cmderr_wdata = 3'd7;
    write_cmd(32'h0000_0000);
    check_eq("t7_set_wins", cmderr, 1);
    finish_clean();
    check_eq("t7_regno_wrap", command, 32'h0008_0000);
    clear_err(3'd7);

    // Autoexec behaviour
    autoexec_trig = 1'b1;
    tick();
`ifdef DM_AUTOEXEC_EN
    check_eq("t8_auto_busy", busy, 1);
    tick();
    check_eq("t8_auto_exec", exec, 1);
    check_eq("t8_auto_cmd", command, 32'h0008_0000);
    finish_clean();
    check_eq("t8_auto_inc", command, 32'h0008_0001);
    cmd_wr = 1'b1; cmd_wdata = 32'h0000_0042; autoexec_trig = 1'b1;
    tick();
    check_eq("t8_wr_wins", command, 32'h0000_0042);
    tick();
    finish_clean();
`else
    check_eq("t8_auto_ignored", busy, 0);
    write_cmd(32'h0000_0007);
    tick();
    autoexec_trig = 1'b1;
    tick();
    check_eq("t8_auto_no_err", cmderr, 0);
    finish_clean();
`endif
    check_eq("t8_idle", busy, 0);

    // Reset and dmactive mid-EXEC
    write_cmd(32'h0000_1234);
    tick();
    write_cmd(32'h0000_0000);
    check_eq("t9_pre_err", cmderr, 1);
    rst_n = 1'b0;
    tick();
    check_eq("t9_rst_exec", exec, 0);
    check_eq("t9_rst_busy", busy, 0);
    check_eq("t9_rst_err", cmderr, 0);
    check_eq("t9_rst_cmd", command, 0);
    rst_n = 1'b1;
    write_cmd(32'h0000_1234);
    tick();
    check_eq("t9_exec_again", exec, 1);
    dmactive = 1'b0;
    tick();
    check_eq("t9_dmact_exec", exec, 0);
    check_eq("t9_dmact_cmd", command, 0);
    dmactive = 1'b1;
    tick();
    check_eq("t9_stays_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
